ahb_slave_mem: RTL and testbench
================================

// Module: ahb_slave_mem
// PURPOSE
//  AHB-Lite slave for the Sobel datapath: byte-addressable local memory that
//  the image-side AHB master writes pixels into and reads results back from.
//  Decodes address/data phases, inserts configurable wait states, flags bad
//  transfers with the two-cycle ERROR response, and exposes a registered read
//  port so the Sobel core can fetch pixels without bus arbitration.
// PARAMETERS
//  ADDR_BITS    8   byte address width; memory depth = 2**ADDR_BITS bytes
//  WAIT_STATES  1   hreadyout-low cycles per data phase (0..7)
// PORTS
//  HCLK        in   1   clock, rising edge
//  HRESET      in   1   reset, asynchronous, active-low
//  hsel        in   1   slave select (address phase)
//  htrans      in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  haddr       in   32  byte address (address phase)
//  hwrite      in   1   1 = write, 0 = read (address phase)
//  hsize       in   3   000 byte, 001 half, 010 word; others illegal
//  hwdata      in   32  write data (data phase)
//  hreadyout   out  1   0 = stall current data phase
//  hresp       out  1   0 OKAY, 1 ERROR
//  hrdata      out  32  read data, valid when hreadyout=1 in read data phase
//  core_raddr  in   ADDR_BITS  Sobel core read address
//  core_rdata  out  8   memory byte at core_raddr, one-cycle latency
// BEHAVIOUR
//  Reset (HRESET=0, async): hreadyout=1, hresp=0, hrdata=0, core_rdata=0,
//   FSM=IDLE, wait counter=0, all memory bytes=0, captured phase cleared.
//   Reset mid-transfer aborts it; a pending write is discarded.
//  Address phase accepted on a rising edge when hsel=1, htrans[1]=1 and
//   hreadyout=1; haddr/hwrite/hsize latched. IDLE/BUSY or hsel=0: no access,
//   next data phase is zero-wait OKAY.
//  Error check at acceptance: hsize>010, haddr[31:ADDR_BITS]!=0, half with
//   haddr[0]=1, word with haddr[1:0]!=0.
//  FSM states IDLE, WAIT, DATA, ERR1, ERR2:
//   IDLE: hreadyout=1. Legal accept -> WAIT (WAIT_STATES>0) else DATA;
//    illegal accept -> ERR1.
//   WAIT: hreadyout=0, counter counts 1..WAIT_STATES, then -> DATA.
//   DATA: hreadyout=1, hresp=0; transfer completes this cycle. New address
//    phase sampled same edge (pipelined): -> WAIT/DATA/ERR1 as above, else IDLE.
//   ERR1: hreadyout=0, hresp=1; -> ERR2. No address phase sampled.
//   ERR2: hreadyout=1, hresp=1; samples next address phase like DATA.
//  Lanes little-endian: byte at addr a on bits [8*(a%4)+7 : 8*(a%4)].
//   Write commits hwdata lanes to memory on the DATA-completing edge only.
//   Read: hrdata drives addressed lanes in DATA, unaddressed lanes 0;
//   hrdata=0 in all other states. ERROR transfers never touch memory.
//  Halfword/word write at a: bytes a..a+1 / a..a+3 updated together.
//  Core port: core_rdata <= mem[core_raddr] every edge. Same-edge bus write
//   to that byte: core_rdata returns old value (read-before-write).
//  Back-to-back write then read same address: read returns new data.
// TESTING
//  1 WAIT_STATES=1: write byte 0xA5 @0x10 (lane 0) -> 1 low cycle, OKAY; read
//    @0x10 -> hrdata=0x000000A5 after 1 wait cycle.
//  2 Word write 0x11223344 @0x20, byte reads 0x20..0x23 -> 0x44,0x33,0x22,
//    0x11 on lanes 0..3; core_raddr=0x22 -> core_rdata=0x22 next cycle.
//  3 Illegal: haddr=0x100, hsize=010 @0x21 -> each gives ERR1 (ready 0,resp 1)
//    then ERR2 (ready 1,resp 1); memory unchanged, next transfer OKAY.
//  4 WAIT_STATES=0 pipelined NONSEQ writes 0x01@0,0x02@1,0x03@2 back-to-back
//    -> hreadyout stays 1, all three bytes read back correctly.
//  5 htrans=BUSY/IDLE or hsel=0 with hwrite=1 -> no memory change, hresp=0.
//  6 Drop HRESET during WAIT of write 0x7E@0x40 -> outputs to reset values
//    immediately; post-reset read @0x40 -> 0x00.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave fronting a byte-addressable local memory, with configurable wait
// states, the two-cycle ERROR response and a registered side read port for the Sobel core.
module ahb_slave_mem #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 hsel,
    input  logic [1:0]           htrans,
    input  logic [31:0]          haddr,
    input  logic                 hwrite,
    input  logic [2:0]           hsize,
    input  logic [31:0]          hwdata,
    output logic                 hreadyout,
    output logic                 hresp,
    output logic [31:0]          hrdata,
    input  logic [ADDR_BITS-1:0] core_raddr,
    output logic [7:0]           core_rdata
);

    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [2:0] WS    = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t               r_state;
    logic [2:0]           r_wcnt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [2:0]           r_size;
    logic                 r_write;
    logic [7:0]           r_mem [DEPTH];

    logic                 w_accept;
    logic                 w_illegal;
    logic                 w_commit;
    logic                 w_wait_done;
    logic [3:0]           w_wmask;
    logic [3:0]           w_rd_mask;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic [2:0]           w_rd_size;
    logic [31:0]          w_rd_word;

    // Byte lanes touched by a transfer of the given size at the given low address bits.
    function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
        logic [3:0] m;
        case (sz)
            3'b000:  m = 4'b0001 << a;
            3'b001:  m = a[1] ? 4'b1100 : 4'b0011;
            3'b010:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Unsupported size, out-of-range address, or misaligned half/word.
    function automatic logic addr_illegal(input logic [31:0] a, input logic [2:0] sz);
        logic hi;
        hi = (a >> ADDR_BITS) != 32'd0;
        return (sz > 3'b010) || hi ||
               ((sz == 3'b001) && a[0]) ||
               ((sz == 3'b010) && (a[1:0] != 2'b00));
    endfunction

    assign w_accept    = hsel && htrans[1] && hreadyout;
    assign w_illegal   = addr_illegal(haddr, hsize);
    assign w_commit    = (r_state == S_DATA) && r_write;
    assign w_wait_done = (r_state == S_WAIT) && (r_wcnt == WS);
    assign w_wmask     = lane_mask(r_addr[1:0], r_size);

    // Read data for a data phase starting next cycle; bytes committed on this edge are
    // forwarded so a back-to-back read sees the freshly written value.
    always_comb begin
        w_rd_word = 32'd0;
        if (r_state == S_WAIT) begin
            w_rd_addr = r_addr;
            w_rd_size = r_size;
        end else begin
            w_rd_addr = haddr[ADDR_BITS-1:0];
            w_rd_size = hsize;
        end
        w_rd_mask = lane_mask(w_rd_addr[1:0], w_rd_size);
        for (int k = 0; k < 4; k++) begin
            if (!w_rd_mask[k]) begin
                w_rd_word[8*k +: 8] = 8'd0;
            end else if (w_commit && w_wmask[k] &&
                         (r_addr[ADDR_BITS-1:2] == w_rd_addr[ADDR_BITS-1:2])) begin
                w_rd_word[8*k +: 8] = hwdata[8*k +: 8];
            end else begin
                w_rd_word[8*k +: 8] = r_mem[{w_rd_addr[ADDR_BITS-1:2], 2'(k)}];
            end
        end
    end

    // Transfer FSM with registered handshake and read-data outputs.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_state   <= S_IDLE;
            r_wcnt    <= 3'd0;
            r_addr    <= '0;
            r_size    <= 3'd0;
            r_write   <= 1'b0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= 32'd0;
        end else begin
            hrdata <= 32'd0;
            case (r_state)
                S_IDLE, S_DATA, S_ERR2: begin
                    if (w_accept) begin
                        r_addr <= haddr[ADDR_BITS-1:0];
                        r_size <= hsize;
                        if (w_illegal) begin
                            r_write   <= 1'b0;
                            r_state   <= S_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                        end else if (WS != 3'd0) begin
                            r_write   <= hwrite;
                            r_state   <= S_WAIT;
                            r_wcnt    <= 3'd1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b0;
                        end else begin
                            r_write   <= hwrite;
                            r_state   <= S_DATA;
                            hreadyout <= 1'b1;
                            hresp     <= 1'b0;
                            hrdata    <= hwrite ? 32'd0 : w_rd_word;
                        end
                    end else begin
                        r_write   <= 1'b0;
                        r_state   <= S_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_wait_done) begin
                        r_state   <= S_DATA;
                        r_wcnt    <= 3'd0;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                        hrdata    <= r_write ? 32'd0 : w_rd_word;
                    end else begin
                        r_wcnt    <= r_wcnt + 3'd1;
                        hreadyout <= 1'b0;
                        hresp     <= 1'b0;
                    end
                end
                S_ERR1: begin
                    r_state   <= S_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_write   <= 1'b0;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                end
            endcase
        end
    end

    // Memory array: bus writes land only on the edge that completes a write data phase.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wmask[k]) begin
                    r_mem[{r_addr[ADDR_BITS-1:2], 2'(k)}] <= hwdata[8*k +: 8];
                end else begin
                    r_mem[{r_addr[ADDR_BITS-1:2], 2'(k)}] <= r_mem[{r_addr[ADDR_BITS-1:2], 2'(k)}];
                end
            end
        end else begin
            r_mem <= r_mem;
        end
    end

    // Core side port: registered read that sees the pre-write value on a same-edge write.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            core_rdata <= 8'd0;
        end else begin
            core_rdata <= r_mem[core_raddr];
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one instance with one wait state, one with none,
// checked each cycle against a transaction-level model plus hand-computed literals.
module tb_ahb_slave_mem;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic [1:0]  hsel_v = 2'b00;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] haddr = 32'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = 32'd0;
    logic [7:0]  core_raddr = 8'd0;
    logic [1:0]  rdy;
    logic [1:0]  rsp;
    logic [31:0] rd0, rd1;
    logic [7:0]  crd0, crd1;

    int n_err = 0;
    int n_chk = 0;

    ahb_slave_mem #(.ADDR_BITS(8), .WAIT_STATES(1)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .hsel(hsel_v[0]), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyout(rdy[0]), .hresp(rsp[0]),
        .hrdata(rd0), .core_raddr(core_raddr), .core_rdata(crd0));

    ahb_slave_mem #(.ADDR_BITS(8), .WAIT_STATES(0)) u_dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .hsel(hsel_v[1]), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyout(rdy[1]), .hresp(rsp[1]),
        .hrdata(rd1), .core_raddr(core_raddr), .core_rdata(crd1));

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // kind: 0 no transfer, 1 legal data phase, 2 error response; cnt = cycles spent in phase
    logic [7:0]  mm [2][256];
    int          kind [2];
    int          cnt [2];
    logic [31:0] p_addr [2];
    int          p_bytes [2];
    bit          p_wr [2];
    logic [7:0]  e_core [2];

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic bit m_ready(input int d);
        if (kind[d] == 1) return cnt[d] >= ws_of(d);
        if (kind[d] == 2) return cnt[d] >= 1;
        return 1'b1;
    endfunction

    function automatic bit m_resp(input int d);
        return kind[d] == 2;
    endfunction

    function automatic logic [31:0] m_rdata(input int d);
        logic [31:0] v;
        int a;
        v = 32'd0;
        if (kind[d] == 1 && !p_wr[d] && cnt[d] >= ws_of(d)) begin
            for (int i = 0; i < p_bytes[d]; i++) begin
                a = int'(p_addr[d]) + i;
                v = v | (32'(mm[d][a]) << (8 * (a % 4)));
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            kind[d] = 0; cnt[d] = 0; e_core[d] = 8'd0;
            p_addr[d] = 32'd0; p_bytes[d] = 0; p_wr[d] = 1'b0;
            for (int i = 0; i < 256; i++) mm[d][i] = 8'd0;
        end
    endtask

    task automatic model_step();
        int a, bytes;
        for (int d = 0; d < 2; d++) begin
            e_core[d] = mm[d][core_raddr];
            if (m_ready(d)) begin
                if (kind[d] == 1 && p_wr[d]) begin
                    for (int i = 0; i < p_bytes[d]; i++) begin
                        a = int'(p_addr[d]) + i;
                        mm[d][a] = hwdata[8 * (a % 4) +: 8];
                    end
                end
                if (hsel_v[d] && htrans[1]) begin
                    bytes = 1 << hsize;
                    if (hsize <= 3'd2 && haddr < 32'd256 && (haddr % bytes) == 0) kind[d] = 1;
                    else kind[d] = 2;
                    cnt[d] = 0; p_addr[d] = haddr; p_bytes[d] = bytes; p_wr[d] = hwrite;
                end else begin
                    kind[d] = 0; cnt[d] = 0;
                end
            end else begin
                cnt[d]++;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge HCLK or negedge HRESET);
            if (!HRESET) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge HCLK);
            chk("d0 hreadyout", 32'(rdy[0]), 32'(m_ready(0)));
            chk("d0 hresp", 32'(rsp[0]), 32'(m_resp(0)));
            chk("d0 hrdata", rd0, m_rdata(0));
            chk("d0 core_rdata", 32'(crd0), 32'(e_core[0]));
            chk("d1 hreadyout", 32'(rdy[1]), 32'(m_ready(1)));
            chk("d1 hresp", 32'(rsp[1]), 32'(m_resp(1)));
            chk("d1 hrdata", rd1, m_rdata(1));
            chk("d1 core_rdata", 32'(crd1), 32'(e_core[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic addr_phase(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz);
        hsel_v = (d == 0) ? 2'b01 : 2'b10;
        htrans = 2'b10;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
    endtask

    task automatic idle_bus();
        hsel_v = 2'b00;
        htrans = 2'b00;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input int exp_wait, input bit exp_resp,
                        input logic [31:0] exp_rd, input string name);
        int n;
        @(posedge HCLK); #1;
        addr_phase(d, wr, a, sz);
        @(posedge HCLK); #1;
        idle_bus();
        hwdata = wd;
        n = 0;
        @(negedge HCLK);
        while (rdy[d] !== 1'b1 && n < 20) begin
            n++;
            @(negedge HCLK);
        end
        if (n >= 20) begin
            n_chk++; n_err++;
            $display("FAIL %s timeout: hreadyout never returned high within 20 cycles", name);
        end else begin
            chk($sformatf("%s waits", name), 32'(n), 32'(exp_wait));
            chk($sformatf("%s hresp", name), 32'(rsp[d]), 32'(exp_resp));
            if (!wr && !exp_resp) chk($sformatf("%s hrdata", name), (d == 0) ? rd0 : rd1, exp_rd);
        end
    endtask

    initial begin
        repeat (2) @(posedge HCLK);
        #1;
        chk("reset hreadyout", 32'(rdy[0]), 32'd1);
        chk("reset hresp", 32'(rsp[0]), 32'd0);
        chk("reset hrdata", rd0, 32'd0);
        chk("reset core_rdata", 32'(crd0), 32'd0);
        HRESET = 1'b1;

        // 1: byte write/read with one wait state
        xfer(0, 1'b1, 32'h10, 3'b000, 32'h000000A5, 1, 1'b0, 32'd0, "t1 wr");
        xfer(0, 1'b0, 32'h10, 3'b000, 32'd0, 1, 1'b0, 32'h000000A5, "t1 rd");

        // 2: word write, byte read-back on each lane, core port
        xfer(0, 1'b1, 32'h20, 3'b010, 32'h11223344, 1, 1'b0, 32'd0, "t2 wr");
        xfer(0, 1'b0, 32'h20, 3'b000, 32'd0, 1, 1'b0, 32'h00000044, "t2 rd20");
        xfer(0, 1'b0, 32'h21, 3'b000, 32'd0, 1, 1'b0, 32'h00003300, "t2 rd21");
        xfer(0, 1'b0, 32'h22, 3'b000, 32'd0, 1, 1'b0, 32'h00220000, "t2 rd22");
        xfer(0, 1'b0, 32'h23, 3'b000, 32'd0, 1, 1'b0, 32'h11000000, "t2 rd23");
        xfer(0, 1'b0, 32'h22, 3'b001, 32'd0, 1, 1'b0, 32'h11220000, "t2 rdhalf");
        core_raddr = 8'h22;
        @(posedge HCLK);
        @(negedge HCLK);
        chk("t2 core d0", 32'(crd0), 32'h22);
        chk("t2 core d1", 32'(crd1), 32'h00);

        // 3: illegal transfers give ERROR and leave memory alone
        xfer(0, 1'b1, 32'h100, 3'b000, 32'h000000FF, 1, 1'b1, 32'd0, "t3 range");
        xfer(0, 1'b1, 32'h21, 3'b010, 32'hDEADBEEF, 1, 1'b1, 32'd0, "t3 wmisal");
        xfer(0, 1'b1, 32'h11, 3'b001, 32'hBEEF0000, 1, 1'b1, 32'd0, "t3 hmisal");
        xfer(0, 1'b0, 32'h20, 3'b011, 32'd0, 1, 1'b1, 32'd0, "t3 size");
        xfer(0, 1'b0, 32'h20, 3'b010, 32'd0, 1, 1'b0, 32'h11223344, "t3 after");
        xfer(0, 1'b0, 32'h00, 3'b000, 32'd0, 1, 1'b0, 32'h00000000, "t3 alias");
        xfer(0, 1'b0, 32'h10, 3'b010, 32'd0, 1, 1'b0, 32'h000000A5, "t3 w10");

        // 4: zero-wait pipelined writes, then write followed directly by read
        @(posedge HCLK); #1;
        addr_phase(1, 1'b1, 32'h0, 3'b000);
        @(posedge HCLK); #1;
        addr_phase(1, 1'b1, 32'h1, 3'b000); hwdata = 32'h00000001;
        @(negedge HCLK); chk("t4 rdy0", 32'(rdy[1]), 32'd1);
        @(posedge HCLK); #1;
        addr_phase(1, 1'b1, 32'h2, 3'b000); hwdata = 32'h00000200;
        @(negedge HCLK); chk("t4 rdy1", 32'(rdy[1]), 32'd1);
        @(posedge HCLK); #1;
        addr_phase(1, 1'b1, 32'h5, 3'b000); hwdata = 32'h00030000;
        @(negedge HCLK); chk("t4 rdy2", 32'(rdy[1]), 32'd1);
        @(posedge HCLK); #1;
        addr_phase(1, 1'b0, 32'h5, 3'b000); hwdata = 32'h00005A00;
        @(negedge HCLK); chk("t4 rdy3", 32'(rdy[1]), 32'd1);
        @(posedge HCLK); #1;
        idle_bus(); hwdata = 32'd0;
        @(negedge HCLK);
        chk("t4 fwd rdy", 32'(rdy[1]), 32'd1);
        chk("t4 fwd data", rd1, 32'h00005A00);
        xfer(1, 1'b0, 32'h0, 3'b000, 32'd0, 0, 1'b0, 32'h00000001, "t4 rd0");
        xfer(1, 1'b0, 32'h1, 3'b000, 32'd0, 0, 1'b0, 32'h00000200, "t4 rd1");
        xfer(1, 1'b0, 32'h2, 3'b000, 32'd0, 0, 1'b0, 32'h00030000, "t4 rd2");
        xfer(1, 1'b0, 32'h0, 3'b010, 32'd0, 0, 1'b0, 32'h00030201, "t4 rdw");

        // 5: BUSY, IDLE and deselected writes have no effect
        @(posedge HCLK); #1;
        hsel_v = 2'b01; htrans = 2'b01; haddr = 32'h10; hwrite = 1'b1; hsize = 3'b000;
        hwdata = 32'h000000FF;
        @(posedge HCLK); #1;
        htrans = 2'b00;
        @(posedge HCLK); #1;
        hsel_v = 2'b00; htrans = 2'b10;
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk("t5 rdy", 32'(rdy[0]), 32'd1);
        chk("t5 resp", 32'(rsp[0]), 32'd0);
        xfer(0, 1'b0, 32'h10, 3'b000, 32'd0, 1, 1'b0, 32'h000000A5, "t5 rd");

        // 6: reset during the wait cycle of a write
        @(posedge HCLK); #1;
        addr_phase(0, 1'b1, 32'h40, 3'b000);
        @(posedge HCLK); #1;
        idle_bus(); hwdata = 32'h0000007E;
        #2;
        chk("t6 in wait", 32'(rdy[0]), 32'd0);
        HRESET = 1'b0;
        #1;
        chk("t6 rst rdy", 32'(rdy[0]), 32'd1);
        chk("t6 rst resp", 32'(rsp[0]), 32'd0);
        chk("t6 rst hrdata", rd0, 32'd0);
        chk("t6 rst core", 32'(crd0), 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        xfer(0, 1'b0, 32'h40, 3'b000, 32'd0, 1, 1'b0, 32'h00000000, "t6 rd40");
        xfer(0, 1'b0, 32'h10, 3'b000, 32'd0, 1, 1'b0, 32'h00000000, "t6 rd10");

        repeat (2) @(negedge HCLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
